// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the request side; the unit drives status and the HI/LO registers.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a final sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave md
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH:0]     accHi_q;
  logic [WIDTH-1:0]   accLo_q, opB_q, aRaw_q;
  logic               isMul_q, negRes_q, negRem_q, divZero_q, ovf_q;

  logic               accept, aNeg, bNeg;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum, mulHi, shifted;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH:0]     accHi_d;
  logic [WIDTH-1:0]   accLo_d;
  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0]   quotFix, remFix, hi_d, lo_d;

  assign accept = md.op_valid && !busy_q && !md.flush;
  assign aNeg   = ~md.op[0] & md.src_a[WIDTH-1];
  assign bNeg   = ~md.op[0] & md.src_b[WIDTH-1];
  assign aMag   = aNeg ? -md.src_a : md.src_a;
  assign bMag   = bNeg ? -md.src_b : md.src_b;

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  // One iteration step; accHi holds partial product / remainder, accLo holds multiplier / quotient.
  always_comb begin
    mulSum  = accHi_q + {1'b0, opB_q};
    mulHi   = accLo_q[0] ? mulSum : accHi_q;
    shifted = {accHi_q[WIDTH-1:0], accLo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opB_q};
    accHi_d = accHi_q;
    accLo_d = accLo_q;
    if (isMul_q) begin
      accHi_d = {1'b0, mulHi[WIDTH:1]};
      accLo_d = {mulHi[0], accLo_q[WIDTH-1:1]};
    end else if (!diff[WIDTH+1]) begin
      accHi_d = diff[WIDTH:0];
      accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
    end else begin
      accHi_d = shifted;
      accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod    = {accHi_q[WIDTH-1:0], accLo_q};
    prodFix = negRes_q ? -prod : prod;
    quotFix = negRes_q ? -accLo_q : accLo_q;
    remFix  = negRem_q ? -accHi_q[WIDTH-1:0] : accHi_q[WIDTH-1:0];
    hi_d    = remFix;
    lo_d    = quotFix;
    if (isMul_q) begin
      hi_d = prodFix[2*WIDTH-1:WIDTH];
      lo_d = prodFix[WIDTH-1:0];
    end else if (divZero_q) begin
      hi_d = aRaw_q;
      lo_d = '1;
    end else if (ovf_q) begin
      hi_d = '0;
      lo_d = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      opB_q     <= '0;
      aRaw_q    <= '0;
      isMul_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!md.op[2]) begin
              state_q   <= CALC;
              busy_q    <= 1'b1;
              count_q   <= '0;
              isMul_q   <= ~md.op[1];
              negRes_q  <= aNeg ^ bNeg;
              negRem_q  <= aNeg;
              aRaw_q    <= md.src_a;
              divZero_q <= md.op[1] && (md.src_b == '0);
              ovf_q     <= (md.op == 3'b010) && (md.src_a == {1'b1, {(WIDTH-1){1'b0}}})
                           && (md.src_b == '1);
              accHi_q   <= '0;
              accLo_q   <= md.op[1] ? aMag : bMag;
              opB_q     <= md.op[1] ? bMag : aMag;
            end else if (md.op == 3'b100) begin
              hi_q <= md.src_a;
            end else if (md.op == 3'b101) begin
              lo_q <= md.src_a;
            end
          end
        end
        CALC: begin
          if (md.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            count_q <= count_q + 1'b1;
            if (count_q == CW'(WIDTH-1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!md.flush) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops push expected HI/LO, a negedge
// monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   busyRun = 0;
  exp_t expQ[$];

  mul_div_unit_if #(.WIDTH(WIDTH)) md ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    md.op_valid = 1'b1;
    md.op       = op;
    md.src_a    = a;
    md.src_b    = b;
    tick();
    md.op_valid = 1'b0;
  endtask

  task automatic pushExp(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (expQ.size() == 0) break;
      tick();
    end
    checkOutput({name, "_drain"}, WIDTH'(expQ.size()), '0);
    expQ.delete();
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] h,
                       input logic [WIDTH-1:0] l);
    pushExp(h, l);
    applyStimulus(op, a, b);
    checkOutput({name, "_busy"}, WIDTH'(md.busy), 1);
    waitDrain(name);
    tick();
  endtask

  // Monitor: every done pulse must match the oldest expectation and follow WIDTH+1 busy cycles.
  always @(negedge clk) begin
    if (rst) begin
      busyRun = 0;
    end else if (md.busy) begin
      busyRun++;
    end else begin
      if (md.done) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("sb_hi", md.hi, e.hi);
          checkOutput("sb_lo", md.lo, e.lo);
          checkOutput("sb_busy_cycles", WIDTH'(busyRun), WIDTH'(WIDTH + 1));
        end
      end
      busyRun = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] prevHi, prevLo;
    md.op_valid = 1'b0;
    md.op       = 3'b000;
    md.src_a    = '0;
    md.src_b    = '0;
    md.flush    = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checkOutput("reset_hi", md.hi, '0);
    checkOutput("reset_lo", md.lo, '0);
    checkOutput("reset_busy", WIDTH'(md.busy), 0);
    checkOutput("reset_done", WIDTH'(md.done), 0);

    runOp("mult_neg1x2",  3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runOp("multu_max_x2", 3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
    runOp("mult_n3xn5",   3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F);
    runOp("multu_maxsq",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    runOp("div_n7_2",     3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_7_n2",     3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    runOp("divu_7_2",     3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
    runOp("divu_by0",     3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    runOp("div_n8_by0",   3'b010, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF);
    runOp("div_ovf",      3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Flush on the 10th busy cycle with the request held; it re-issues once idle.
    prevHi = md.hi;
    prevLo = md.lo;
    md.op_valid = 1'b1;
    md.op       = 3'b010;
    md.src_a    = 32'd100;
    md.src_b    = 32'd7;
    tick();
    checkOutput("flush_busy_start", WIDTH'(md.busy), 1);
    repeat (9) tick();
    checkOutput("flush_busy_10", WIDTH'(md.busy), 1);
    md.flush = 1'b1;
    tick();
    checkOutput("flush_busy_after", WIDTH'(md.busy), 0);
    checkOutput("flush_done_after", WIDTH'(md.done), 0);
    checkOutput("flush_hi_kept", md.hi, prevHi);
    checkOutput("flush_lo_kept", md.lo, prevLo);
    md.flush = 1'b0;
    pushExp(32'd2, 32'd14);
    tick();
    checkOutput("held_reaccepted", WIDTH'(md.busy), 1);
    md.op_valid = 1'b0;
    waitDrain("held_div");
    tick();

    // Flush in the same cycle as an idle MTHI blocks it.
    md.flush = 1'b1;
    applyStimulus(3'b100, 32'hDEADBEEF, '0);
    md.flush = 1'b0;
    checkOutput("flush_mthi_blocked", md.hi, 32'd2);

    md.op_valid = 1'b1;
    md.op       = 3'b100;
    md.src_a    = 32'h12345678;
    tick();
    checkOutput("mthi_hi", md.hi, 32'h12345678);
    checkOutput("mthi_busy", WIDTH'(md.busy), 0);
    checkOutput("mthi_done", WIDTH'(md.done), 0);
    md.op    = 3'b101;
    md.src_a = 32'h9ABCDEF0;
    tick();
    md.op_valid = 1'b0;
    checkOutput("mtlo_lo", md.lo, 32'h9ABCDEF0);
    checkOutput("mtlo_hi_kept", md.hi, 32'h12345678);
    checkOutput("mtlo_busy", WIDTH'(md.busy), 0);
    checkOutput("mtlo_done", WIDTH'(md.done), 0);

    applyStimulus(3'b110, 32'h11111111, 32'h22222222);
    checkOutput("rsvd_busy", WIDTH'(md.busy), 0);
    checkOutput("rsvd_hi", md.hi, 32'h12345678);
    checkOutput("rsvd_lo", md.lo, 32'h9ABCDEF0);

    // Back-to-back: second MULTU issued in the done cycle of the first.
    pushExp(32'd0, 32'd15);
    applyStimulus(3'b001, 32'd3, 32'd5);
    for (int i = 0; i < 60; i++) begin
      if (md.done) break;
      tick();
    end
    checkOutput("b2b_done_seen", WIDTH'(md.done), 1);
    pushExp(32'd1, 32'd0);
    applyStimulus(3'b001, 32'h00010000, 32'h00010000);
    checkOutput("b2b_accepted", WIDTH'(md.busy), 1);
    waitDrain("b2b");
    tick();

    // Reset on the 5th busy cycle of a MULTU discards it.
    applyStimulus(3'b001, 32'd6, 32'd7);
    repeat (4) tick();
    checkOutput("rst_mid_busy", WIDTH'(md.busy), 1);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_hi", md.hi, '0);
    checkOutput("rst_mid_lo", md.lo, '0);
    checkOutput("rst_mid_busy_after", WIDTH'(md.busy), 0);
    checkOutput("rst_mid_done", WIDTH'(md.done), 0);
    rst = 1'b0;
    repeat (40) tick();
    checkOutput("rst_no_late_done_lo", md.lo, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
